// File: rtl/vx_wnd_spill_ctrl.sv
// vx_wnd_spill_ctrl
//   Per-warp register-window controller. Tracks, for every warp, the current
//   window pointer (cwp), the number of resident physical windows (res) and
//   the number of windows spilled to memory (sp). A save (call) or restore
//   (return) either moves the window pointer locally, or has to spill the
//   oldest resident window to memory or fill one back first. During a
//   spill/fill the owning warp is descheduled and no new commands are taken.
//
// Ports
//   clk, nRST          clock, synchronous active-low reset
//   cmd_valid/cmd_save/cmd_warp/cmd_ready
//                      save(1)/restore(0) command; taken when cmd_ready=1
//   q_warp, q_cwp      combinational window-pointer lookup
//   deschedule[NW]     one-hot stall of the warp being spilled/filled
//   mem_req_*          one register transfer per beat (rw=1 spill write)
//   mem_rsp_valid      one pulse per returned fill read
//   err[NW]            sticky per-warp overflow/underflow flag
module vx_wnd_spill_ctrl #(
    parameter int  W    = 2,
    parameter int  O    = 20,
    parameter int  NWIN = 4,
    parameter int  MAXD = 8,
    localparam int NW   = 1 << W,
    localparam int CW   = (NWIN > 1) ? $clog2(NWIN) : 1,
    localparam int RW   = (O > 1) ? $clog2(O) : 1
) (
    input  logic          clk,
    input  logic          nRST,
    input  logic          cmd_valid,
    input  logic          cmd_save,
    input  logic [W-1:0]  cmd_warp,
    output logic          cmd_ready,
    input  logic [W-1:0]  q_warp,
    output logic [CW-1:0] q_cwp,
    output logic [NW-1:0] deschedule,
    output logic          mem_req_valid,
    output logic          mem_req_rw,
    output logic [CW-1:0] mem_req_win,
    output logic [RW-1:0] mem_req_reg,
    output logic [31:0]   mem_req_addr,
    input  logic          mem_req_ready,
    input  logic          mem_rsp_valid,
    output logic [NW-1:0] err
);
    localparam int RESW = $clog2(NWIN + 1);
    localparam int SPW  = $clog2(MAXD + 1);
    localparam int CNTW = $clog2(O + 1);

    localparam logic [RESW-1:0] RES_ONE  = RESW'(1);
    localparam logic [RESW-1:0] RES_FULL = RESW'(NWIN);
    localparam logic [SPW-1:0]  SP_MAX   = SPW'(MAXD);
    localparam logic [RW-1:0]   REQ_LAST = RW'(O - 1);
    localparam logic [CNTW-1:0] RSP_LAST = CNTW'(O - 1);

    typedef enum logic [1:0] {IDLE, SPILL, FILL_REQ, FILL_WAIT} state_t;

    typedef struct packed {
        logic [CW-1:0]   cwp;
        logic [RESW-1:0] res;
        logic [SPW-1:0]  sp;
    } wst_t;

    state_t          state;
    wst_t            ws [NW];
    wst_t            cw;
    logic [W-1:0]    cur_warp;
    logic [CW-1:0]   cur_win;
    logic [SPW-1:0]  cur_depth;
    logic [RW-1:0]   req_cnt;
    logic [CNTW-1:0] rsp_cnt;

    assign cw            = ws[cmd_warp];
    assign q_cwp         = ws[q_warp].cwp;
    assign cmd_ready     = (state == IDLE);
    assign mem_req_valid = (state == SPILL) || (state == FILL_REQ);
    assign mem_req_rw    = (state == SPILL);
    assign mem_req_win   = cur_win;
    assign mem_req_reg   = req_cnt;
    assign mem_req_addr  = ((32'(cur_warp) * 32'(MAXD) + 32'(cur_depth)) * 32'(O))
                           + 32'(req_cnt);

    // cwp arithmetic relies on NWIN being a power of two: the CW-bit
    // add/subtract wraps modulo NWIN for free.
    always_ff @(posedge clk) begin
        if (!nRST) begin
            state      <= IDLE;
            for (int i = 0; i < NW; i++)
                ws[i] <= '{cwp: '0, res: RES_ONE, sp: '0};
            err        <= '0;
            deschedule <= '0;
            cur_warp   <= '0;
            cur_win    <= '0;
            cur_depth  <= '0;
            req_cnt    <= '0;
            rsp_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_save) begin
                            if (cw.res != RES_FULL) begin
                                ws[cmd_warp].cwp <= cw.cwp + 1'b1;
                                ws[cmd_warp].res <= cw.res + 1'b1;
                            end else if (cw.sp != SP_MAX) begin
                                // new window lands on the oldest resident one
                                state                <= SPILL;
                                cur_warp             <= cmd_warp;
                                cur_win              <= cw.cwp + 1'b1;
                                cur_depth            <= cw.sp;
                                req_cnt              <= '0;
                                deschedule[cmd_warp] <= 1'b1;
                            end else begin
                                err[cmd_warp] <= 1'b1;
                            end
                        end else begin
                            if (cw.res != RES_ONE) begin
                                ws[cmd_warp].cwp <= cw.cwp - 1'b1;
                                ws[cmd_warp].res <= cw.res - 1'b1;
                            end else if (cw.sp != '0) begin
                                state                <= FILL_REQ;
                                cur_warp             <= cmd_warp;
                                cur_win              <= cw.cwp - 1'b1;
                                cur_depth            <= cw.sp - 1'b1;
                                req_cnt              <= '0;
                                rsp_cnt              <= '0;
                                deschedule[cmd_warp] <= 1'b1;
                            end else begin
                                err[cmd_warp] <= 1'b1;
                            end
                        end
                    end
                end
                SPILL: begin
                    if (mem_req_ready) begin
                        if (req_cnt == REQ_LAST) begin
                            // res stays full: the spilled slot is reused
                            ws[cur_warp].cwp <= cur_win;
                            ws[cur_warp].sp  <= cur_depth + 1'b1;
                            deschedule       <= '0;
                            req_cnt          <= '0;
                            state            <= IDLE;
                        end else begin
                            req_cnt <= req_cnt + 1'b1;
                        end
                    end
                end
                FILL_REQ, FILL_WAIT: begin
                    if (state == FILL_REQ && mem_req_ready) begin
                        if (req_cnt == REQ_LAST) begin
                            req_cnt <= '0;
                            state   <= FILL_WAIT;
                        end else begin
                            req_cnt <= req_cnt + 1'b1;
                        end
                    end
                    // responses may overlap the request phase; completion
                    // overrides the request bookkeeping above
                    if (mem_rsp_valid) begin
                        if (rsp_cnt == RSP_LAST) begin
                            ws[cur_warp].cwp <= cur_win;
                            ws[cur_warp].sp  <= cur_depth;
                            deschedule       <= '0;
                            req_cnt          <= '0;
                            rsp_cnt          <= '0;
                            state            <= IDLE;
                        end else begin
                            rsp_cnt <= rsp_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vx_wnd_spill_ctrl.sv
module tb_vx_wnd_spill_ctrl;
    localparam int W = 2, O = 20, NWIN = 4, MAXD = 8, NW = 4;

    logic          clk = 1'b0;
    logic          nRST;
    logic          cmd_valid, cmd_save;
    logic [W-1:0]  cmd_warp, q_warp;
    logic          cmd_ready;
    logic [1:0]    q_cwp;
    logic [NW-1:0] deschedule, err;
    logic          mem_req_valid, mem_req_rw, mem_req_ready, mem_rsp_valid;
    logic [1:0]    mem_req_win;
    logic [4:0]    mem_req_reg;
    logic [31:0]   mem_req_addr;

    vx_wnd_spill_ctrl #(.W(W), .O(O), .NWIN(NWIN), .MAXD(MAXD)) dut (
        .clk(clk), .nRST(nRST),
        .cmd_valid(cmd_valid), .cmd_save(cmd_save), .cmd_warp(cmd_warp),
        .cmd_ready(cmd_ready), .q_warp(q_warp), .q_cwp(q_cwp),
        .deschedule(deschedule), .mem_req_valid(mem_req_valid),
        .mem_req_rw(mem_req_rw), .mem_req_win(mem_req_win),
        .mem_req_reg(mem_req_reg), .mem_req_addr(mem_req_addr),
        .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
        .err(err)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    // reference model: plain per-warp counters plus a queue of the
    // transfers the controller still owes
    typedef struct { int addr; int rg; } xfer_t;
    xfer_t      m_q[$];
    int         m_cwp[NW], m_res[NW], m_sp[NW];
    logic [3:0] m_err;
    int         m_mode;        // 0 idle, 1 spilling, 2 filling
    int         m_xw, m_xwin, m_rsp_left, outstanding;

    logic dut_acc;
    int   dut_addr, dut_win;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < NW; i++) begin m_cwp[i] = 0; m_res[i] = 1; m_sp[i] = 0; end
        m_err = '0; m_mode = 0; m_rsp_left = 0; outstanding = 0; m_q.delete();
    endfunction

    function automatic void m_start(input int mode, input int w, input int win, input int depth);
        m_mode = mode; m_xw = w; m_xwin = win; m_rsp_left = O;
        for (int r = 0; r < O; r++) m_q.push_back('{(w * MAXD + depth) * O + r, r});
    endfunction

    function automatic void m_cmd(input bit save, input int w);
        if (save) begin
            if (m_res[w] < NWIN) begin m_cwp[w] = (m_cwp[w] + 1) % NWIN; m_res[w]++; end
            else if (m_sp[w] < MAXD) m_start(1, w, (m_cwp[w] + 1) % NWIN, m_sp[w]);
            else m_err[w] = 1'b1;
        end else begin
            if (m_res[w] > 1) begin m_cwp[w] = (m_cwp[w] + NWIN - 1) % NWIN; m_res[w]--; end
            else if (m_sp[w] > 0) m_start(2, w, (m_cwp[w] + NWIN - 1) % NWIN, m_sp[w] - 1);
            else m_err[w] = 1'b1;
        end
    endfunction

    task automatic check_outputs();
        bit exp_valid;
        exp_valid = (m_mode != 0) && (m_q.size() > 0);
        chk("cmd_ready", cmd_ready, m_mode == 0);
        chk("deschedule", deschedule, (m_mode != 0) ? (32'd1 << m_xw) : 32'd0);
        chk("mem_req_valid", mem_req_valid, exp_valid);
        if (exp_valid && mem_req_valid) begin
            chk("mem_req_rw", mem_req_rw, m_mode == 1);
            chk("mem_req_win", mem_req_win, m_xwin);
            chk("mem_req_reg", mem_req_reg, m_q[0].rg);
            chk("mem_req_addr", mem_req_addr, m_q[0].addr);
        end
        chk("err", err, m_err);
        chk("q_cwp", q_cwp, m_cwp[q_warp]);
    endtask

    // one clock: check outputs for the driven inputs, then advance model
    task automatic tick();
        bit acc_cmd, acc_req, acc_rsp, rd_acc, c_save;
        int c_warp;
        #1;
        check_outputs();
        dut_acc  = mem_req_valid && mem_req_ready;
        dut_addr = mem_req_addr;
        dut_win  = mem_req_win;
        acc_cmd  = nRST && cmd_valid && m_mode == 0;
        acc_req  = nRST && m_mode != 0 && m_q.size() > 0 && mem_req_ready;
        acc_rsp  = nRST && mem_rsp_valid && m_mode == 2;
        rd_acc   = acc_req && m_mode == 2;
        c_save   = cmd_save;
        c_warp   = cmd_warp;
        @(posedge clk);
        if (!nRST) m_reset();
        else begin
            if (rd_acc) outstanding++;
            if (mem_rsp_valid && outstanding > 0) outstanding--;
            if (acc_cmd) m_cmd(c_save, c_warp);
            if (acc_req) begin
                void'(m_q.pop_front());
                if (m_mode == 1 && m_q.size() == 0) begin
                    m_cwp[m_xw] = m_xwin; m_sp[m_xw]++; m_mode = 0;
                end
            end
            if (acc_rsp) begin
                m_rsp_left--;
                if (m_rsp_left == 0) begin
                    m_cwp[m_xw] = m_xwin; m_sp[m_xw]--; m_mode = 0;
                end
            end
        end
        #1;
    endtask

    task automatic do_cmd(input bit save, input int w);
        cmd_valid = 1'b1; cmd_save = save; cmd_warp = w;
        tick();
        cmd_valid = 1'b0;
    endtask

    // run the pending transfer to completion; tog=1 gives 50% backpressure
    task automatic drain(input bit tog, output int n, output int first_addr, output int win);
        n = 0; first_addr = -1; win = -1;
        cmd_valid = 1'b0;
        for (int c = 0; c < 400 && m_mode != 0; c++) begin
            mem_req_ready = tog ? (c % 2 == 1) : 1'b1;
            mem_rsp_valid = (outstanding > 0);
            tick();
            if (dut_acc) begin
                if (n == 0) begin first_addr = dut_addr; win = dut_win; end
                n++;
            end
        end
        if (m_mode != 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout: transfer still busy after 400 cycles, expected idle");
        end
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    endtask

    typedef struct { bit save; int warp; int exp_cwp; logic [3:0] exp_err; } vec_t;
    vec_t tbl[12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int n, fa, win;
        tbl[0]  = '{1, 0, 1, 4'b0000};
        tbl[1]  = '{1, 0, 2, 4'b0000};
        tbl[2]  = '{1, 0, 3, 4'b0000};
        tbl[3]  = '{0, 0, 2, 4'b0000};
        tbl[4]  = '{1, 0, 3, 4'b0000};
        tbl[5]  = '{0, 2, 0, 4'b0100};   // underflow on a fresh warp
        tbl[6]  = '{1, 1, 1, 4'b0100};
        tbl[7]  = '{0, 1, 0, 4'b0100};
        tbl[8]  = '{1, 3, 1, 4'b0100};
        tbl[9]  = '{1, 3, 2, 4'b0100};
        tbl[10] = '{0, 3, 1, 4'b0100};
        tbl[11] = '{1, 3, 2, 4'b0100};

        nRST = 1'b0; cmd_valid = 0; cmd_save = 0; cmd_warp = 0; q_warp = 0;
        mem_req_ready = 0; mem_rsp_valid = 0;
        m_reset();
        @(posedge clk); #1;
        tick();
        chk("reset_ready", cmd_ready, 1'b1);
        chk("reset_req_valid", mem_req_valid, 1'b0);
        nRST = 1'b1;

        // local save/restore table: never touches memory
        for (int i = 0; i < 12; i++) begin
            do_cmd(tbl[i].save, tbl[i].warp);
            q_warp = tbl[i].warp;
            #1;
            chk($sformatf("tbl%0d_cwp", i), q_cwp, tbl[i].exp_cwp);
            chk($sformatf("tbl%0d_err", i), err, tbl[i].exp_err);
            chk($sformatf("tbl%0d_ready", i), cmd_ready, 1'b1);
            chk($sformatf("tbl%0d_noreq", i), mem_req_valid, 1'b0);
        end

        // warp0 full: spill window 0 at depth 0
        do_cmd(1, 0);
        chk("spill0_desched", deschedule, 4'b0001);
        drain(0, n, fa, win);
        chk("spill0_count", n, 20);
        chk("spill0_addr0", fa, 0);
        chk("spill0_win", win, 0);
        q_warp = 0; #1;
        chk("spill0_cwp", q_cwp, 0);
        chk("spill0_desched_off", deschedule, 4'b0000);

        // second spill under 50% backpressure: window 1, depth 1
        do_cmd(1, 0);
        drain(1, n, fa, win);
        chk("spill1_count", n, 20);
        chk("spill1_addr0", fa, 20);
        chk("spill1_win", win, 1);
        q_warp = 0; #1;
        chk("spill1_cwp", q_cwp, 1);

        // warp1: build res=1 sp=2, then fill window 1 from depth 1
        for (int i = 0; i < 3; i++) do_cmd(1, 1);
        for (int i = 0; i < 2; i++) begin do_cmd(1, 1); drain(0, n, fa, win); end
        for (int i = 0; i < 3; i++) do_cmd(0, 1);
        do_cmd(0, 1);
        chk("fill_desched", deschedule, 4'b0010);
        drain(0, n, fa, win);
        chk("fill_count", n, 20);
        chk("fill_addr0", fa, 180);
        chk("fill_win", win, 1);
        q_warp = 1; #1;
        chk("fill_cwp", q_cwp, 1);

        // reset in the middle of a spill after 7 accepted writes
        do_cmd(1, 0);
        n = 0;
        mem_req_ready = 1'b1;
        for (int c = 0; c < 50 && n < 7; c++) begin
            tick();
            if (dut_acc) n++;
        end
        chk("rst_accepts", n, 7);
        nRST = 1'b0;
        tick();
        nRST = 1'b1; mem_req_ready = 1'b0;
        chk("rst_req_valid", mem_req_valid, 1'b0);
        chk("rst_desched", deschedule, 4'b0000);
        chk("rst_err", err, 4'b0000);
        chk("rst_ready", cmd_ready, 1'b1);
        for (int w = 0; w < NW; w++) begin
            q_warp = w; #1;
            chk($sformatf("rst_cwp%0d", w), q_cwp, 0);
        end
        // stray responses after reset are ignored
        mem_rsp_valid = 1'b1;
        repeat (3) tick();
        mem_rsp_valid = 1'b0;

        // overflow: NWIN-1 local saves, MAXD spills, then one too many
        q_warp = 2;
        for (int i = 0; i < MAXD + NWIN; i++) begin
            do_cmd(1, 2);
            if (m_mode != 0) drain(0, n, fa, win);
            chk($sformatf("ovf_err_%0d", i), err[2], i == MAXD + NWIN - 1);
        end
        chk("ovf_nostall", cmd_ready, 1'b1);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            cmd_valid     = ($urandom % 3 == 0);
            cmd_save      = $urandom % 2;
            cmd_warp      = $urandom % NW;
            mem_req_ready = $urandom % 2;
            mem_rsp_valid = (outstanding > 0) && ($urandom % 2 == 1);
            q_warp        = $urandom % NW;
            tick();
        end
        drain(0, n, fa, win);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
